maze_gen_ctrl: RTL and testbench

Parametrised maze generator with a start/done handshake, rectangular odd-sized grid, two generation algorithms and a registered row-read port. Replaces the fixed-square, free-running generator. A seeded 16-bit LFSR drives all random choices, so the bench's reference model can reproduce every maze bit-exactly. Sits between the seed/config source and any maze consumer (file dump, display, solver), which reads one row per cycle after `done`.

---
 rtl/maze_gen_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_maze_gen_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_gen_ctrl.sv
// maze_gen_ctrl: seeded maze generator (DFS backtracker or binary tree) over an
// odd-sized H x W wall grid, with a registered one-row-per-cycle read port.
module maze_gen_ctrl #(
  parameter  int unsigned W           = 17,
  parameter  int unsigned H           = 17,
  localparam int unsigned N           = ((W - 1) / 2) * ((H - 1) / 2),
  parameter  int unsigned STACK_DEPTH = N
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [15:0]          seed,
  input  logic                 mode,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  input  logic [$clog2(H)-1:0] rd_row,
  output logic [W-1:0]         rd_data
);

  localparam int unsigned XW  = $clog2(W);
  localparam int unsigned YW  = $clog2(H);
  localparam int unsigned AW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int unsigned SPW = $clog2(STACK_DEPTH + 1);
  localparam logic [15:0] LFSR_INIT = 16'hACE1;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STEP,
    S_CELL,
    S_FINISH,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [W-1:0]   grid [H];
  logic [XW-1:0]  stk_x [STACK_DEPTH];
  logic [YW-1:0]  stk_y [STACK_DEPTH];
  logic [SPW-1:0] sp;
  logic [15:0]    lfsr, lfsr_n;
  logic           ovf_pend;
  logic [XW-1:0]  bx;
  logic [YW-1:0]  by;

  logic           start_acc;
  logic           stack_full;
  logic [XW-1:0]  top_x;
  logic [YW-1:0]  top_y;
  logic [3:0]     cand;
  logic [2:0]     k;
  logic [1:0]     sel_idx;
  logic [1:0]     dir;
  logic [1:0]     seen;
  logic           found;
  logic [XW-1:0]  nx, wx;
  logic [YW-1:0]  ny, wy;
  logic           bt_north, bt_west, bt_take_north, bt_last_col, bt_last;
  logic [XW-1:0]  bwx;
  logic [YW-1:0]  bwy;

  assign start_acc  = start && ((state == S_IDLE) || (state == S_DONE));
  assign stack_full = (sp == SPW'(STACK_DEPTH));
  assign lfsr_n     = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);

  // DFS neighbour scan around the top-of-stack cell, order N, E, S, W
  always_comb begin
    top_x   = stk_x[AW'(sp - SPW'(1))];
    top_y   = stk_y[AW'(sp - SPW'(1))];
    cand    = '0;
    cand[0] = (top_y > YW'(2)) && grid[top_y - YW'(2)][top_x];
    cand[1] = (top_x < XW'(W - 3)) && grid[top_y][top_x + XW'(2)];
    cand[2] = (top_y < YW'(H - 3)) && grid[top_y + YW'(2)][top_x];
    cand[3] = (top_x > XW'(2)) && grid[top_y][top_x - XW'(2)];
    k = 3'(cand[0]) + 3'(cand[1]) + 3'(cand[2]) + 3'(cand[3]);
  end

  // index = lfsr[1:0] mod k, then pick the index-th present candidate
  always_comb begin
    sel_idx = lfsr[1:0];
    case (k)
      3'd1:    sel_idx = 2'd0;
      3'd2:    sel_idx = {1'b0, lfsr[0]};
      3'd3:    sel_idx = (lfsr[1:0] == 2'd3) ? 2'd0 : lfsr[1:0];
      default: sel_idx = lfsr[1:0];
    endcase
    dir   = 2'd0;
    seen  = 2'd0;
    found = 1'b0;
    for (int d = 0; d < 4; d++) begin
      if (cand[d] && !found) begin
        if (seen == sel_idx) begin
          dir   = 2'(d);
          found = 1'b1;
        end
        seen = seen + 2'd1;
      end
    end
  end

  // chosen cell and the wall between it and the current cell
  always_comb begin
    nx = top_x;
    ny = top_y;
    wx = top_x;
    wy = top_y;
    case (dir)
      2'd0: begin ny = top_y - YW'(2); wy = top_y - YW'(1); end
      2'd1: begin nx = top_x + XW'(2); wx = top_x + XW'(1); end
      2'd2: begin ny = top_y + YW'(2); wy = top_y + YW'(1); end
      default: begin nx = top_x - XW'(2); wx = top_x - XW'(1); end
    endcase
  end

  // binary-tree carve choice for the cursor cell
  always_comb begin
    bt_north      = (by > YW'(1));
    bt_west       = (bx > XW'(1));
    bt_take_north = bt_north && (!bt_west || !lfsr[0]);
    bwx           = bt_take_north ? bx : (bx - XW'(1));
    bwy           = bt_take_north ? (by - YW'(1)) : by;
    bt_last_col   = (bx == XW'(W - 2));
    bt_last       = bt_last_col && (by == YW'(H - 2));
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_n = mode ? S_CELL : S_STEP;
      S_STEP: begin
        if (k != 3'd0) begin
          if (stack_full) state_n = S_FINISH;
        end else if (sp == SPW'(1)) begin
          state_n = S_FINISH;
        end
      end
      S_CELL:   if (bt_last) state_n = S_FINISH;
      S_FINISH: state_n = S_DONE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  // grid, LFSR, stack pointer, cursor and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int y = 0; y < H; y++) grid[y] <= '1;
      lfsr     <= LFSR_INIT;
      sp       <= '0;
      ovf_pend <= 1'b0;
      bx       <= XW'(1);
      by       <= YW'(1);
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      rd_data  <= '0;
    end else begin
      busy    <= (state_n == S_STEP) || (state_n == S_CELL) || (state_n == S_FINISH);
      done    <= (state_n == S_DONE);
      rd_data <= (rd_row <= YW'(H - 1)) ? grid[rd_row] : '1;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            for (int y = 0; y < H; y++) grid[y] <= '1;
            lfsr     <= (seed == 16'h0000) ? LFSR_INIT : seed;
            overflow <= 1'b0;
            ovf_pend <= 1'b0;
            bx       <= XW'(1);
            by       <= YW'(1);
            if (!mode) begin
              grid[YW'(1)][XW'(1)] <= 1'b0;
              sp <= SPW'(1);
            end else begin
              sp <= '0;
            end
          end
        end
        S_STEP: begin
          lfsr <= lfsr_n;
          if (k != 3'd0) begin
            grid[ny][nx] <= 1'b0;
            grid[wy][wx] <= 1'b0;
            if (stack_full) ovf_pend <= 1'b1;
            else            sp <= sp + SPW'(1);
          end else begin
            sp <= sp - SPW'(1);
          end
        end
        S_CELL: begin
          lfsr <= lfsr_n;
          grid[by][bx] <= 1'b0;
          if (bt_north || bt_west) grid[bwy][bwx] <= 1'b0;
          if (bt_last_col) begin
            bx <= XW'(1);
            by <= by + YW'(2);
          end else begin
            bx <= bx + XW'(2);
          end
        end
        S_FINISH: begin
          grid[YW'(1)][XW'(0)]         <= 1'b0;
          grid[YW'(H - 2)][XW'(W - 1)] <= 1'b0;
          overflow <= ovf_pend;
        end
        default: ;
      endcase
    end
  end

  // stack storage needs no reset: only entries below sp are ever read
  always_ff @(posedge clk) begin
    if (start_acc && !mode) begin
      stk_x[0] <= XW'(1);
      stk_y[0] <= YW'(1);
    end else if ((state == S_STEP) && (k != 3'd0) && !stack_full) begin
      stk_x[AW'(sp)] <= nx;
      stk_y[AW'(sp)] <= ny;
    end
  end

endmodule

// File: tb/tb_maze_gen_ctrl.sv
// tb_maze_gen_ctrl: scoreboard bench for maze_gen_ctrl; instances cover 17x17 DFS,
// 9x7 binary tree and a 17x17 DFS with a 4-entry stack.
module tb_maze_gen_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [4:0]  rd_row;
  logic [15:0] seed_v [3];
  logic [2:0]  mode_v, start_v, busy_v, done_v, ovf_v;
  logic [16:0] rd_data_a, rd_data_c;
  logic [8:0]  rd_data_b;

  maze_gen_ctrl #(.W(17), .H(17)) dut_a (
    .clk(clk), .reset(reset), .seed(seed_v[0]), .mode(mode_v[0]), .start(start_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .overflow(ovf_v[0]),
    .rd_row(rd_row), .rd_data(rd_data_a));

  maze_gen_ctrl #(.W(9), .H(7)) dut_b (
    .clk(clk), .reset(reset), .seed(seed_v[1]), .mode(mode_v[1]), .start(start_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .overflow(ovf_v[1]),
    .rd_row(rd_row[2:0]), .rd_data(rd_data_b));

  maze_gen_ctrl #(.W(17), .H(17), .STACK_DEPTH(4)) dut_c (
    .clk(clk), .reset(reset), .seed(seed_v[2]), .mode(mode_v[2]), .start(start_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .overflow(ovf_v[2]),
    .rd_row(rd_row), .rd_data(rd_data_c));

  typedef struct {
    int          id;
    int          row;
    logic [16:0] exp;
    logic [16:0] mask;
    string       name;
  } rd_exp_t;

  typedef struct {
    int    id;
    int    t_acc;
    int    lat;
    logic  ovf;
    string name;
  } dn_exp_t;

  rd_exp_t     rq[$];
  dn_exp_t     dq[$];
  rd_exp_t     me;
  dn_exp_t     de;
  logic [16:0] mact;
  logic [16:0] cap [17];
  bit          mref [17][17];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic        rd_issue = 1'b0;
  logic        rd_vld   = 1'b0;
  logic [2:0]  done_prev = 3'b000;
  bit          bd_viol = 1'b0;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    rd_vld <= rd_issue;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // read-port monitor: one expected entry per issued read
  always @(negedge clk) begin
    if (rd_vld) begin
      if (rq.size() == 0) begin
        check("unexpected read data", 32'd1, 32'd0);
      end else begin
        me   = rq.pop_front();
        mact = (me.id == 1) ? {8'b0, rd_data_b} : (me.id == 2) ? rd_data_c : rd_data_a;
        cap[me.row] = mact;
        check(me.name, 32'(mact & me.mask), 32'(me.exp & me.mask));
      end
    end
  end

  // completion monitor: latency and overflow at each rising done
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done_v[i] && !done_prev[i]) begin
        if (dq.size() == 0 || dq[0].id != i) begin
          check($sformatf("unexpected done on dut %0d", i), 32'd1, 32'd0);
        end else begin
          de = dq.pop_front();
          check({de.name, " done latency"}, 32'(cyc - de.t_acc), 32'(de.lat));
          check({de.name, " overflow at done"}, 32'(ovf_v[i]), 32'(de.ovf));
        end
      end
    end
    done_prev = done_v;
    if ((busy_v & done_v) != 3'b000) bd_viol = 1'b1;
  end

  function automatic logic [15:0] adv(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // reference maze generator writing mref[y][x]
  task automatic model_gen(input int w, input int h, input int depth, input logic [15:0] sd,
                           input bit md, output int lat, output bit ovf);
    logic [15:0] l;
    int sx[$], sy[$];
    int cx, cy, k, pick, nx, ny;
    int cdx[4], cdy[4];
    int dx[4] = '{0, 2, 0, -2};
    int dy[4] = '{-2, 0, 2, 0};
    l   = (sd == 16'h0000) ? 16'hACE1 : sd;
    lat = 0;
    ovf = 1'b0;
    for (int y = 0; y < 17; y++) for (int x = 0; x < 17; x++) mref[y][x] = 1'b1;
    if (!md) begin
      mref[1][1] = 1'b0;
      sx.push_back(1);
      sy.push_back(1);
      while (1) begin
        lat++;
        cx = sx[$];
        cy = sy[$];
        k  = 0;
        for (int d = 0; d < 4; d++) begin
          nx = cx + dx[d];
          ny = cy + dy[d];
          if (nx >= 1 && nx <= w - 2 && ny >= 1 && ny <= h - 2) begin
            if (mref[ny][nx]) begin
              cdx[k] = nx;
              cdy[k] = ny;
              k++;
            end
          end
        end
        if (k > 0) begin
          pick = int'(l[1:0]) % k;
          mref[cdy[pick]][cdx[pick]] = 1'b0;
          mref[(cy + cdy[pick]) / 2][(cx + cdx[pick]) / 2] = 1'b0;
          if (sx.size() == depth) begin
            ovf = 1'b1;
            break;
          end
          sx.push_back(cdx[pick]);
          sy.push_back(cdy[pick]);
        end else begin
          void'(sx.pop_back());
          void'(sy.pop_back());
          if (sx.size() == 0) break;
        end
        l = adv(l);
      end
    end else begin
      for (int y = 1; y <= h - 2; y += 2) begin
        for (int x = 1; x <= w - 2; x += 2) begin
          lat++;
          mref[y][x] = 1'b0;
          if (y > 1 && (x == 1 || l[0] == 1'b0)) mref[y - 1][x] = 1'b0;
          else if (x > 1)                        mref[y][x - 1] = 1'b0;
          l = adv(l);
        end
      end
    end
    lat++;
    mref[1][0]         = 1'b0;
    mref[h - 2][w - 1] = 1'b0;
  endtask

  function automatic logic [16:0] mrow(input int y, input int w);
    logic [16:0] r = '0;
    for (int x = 0; x < w; x++) r[x] = mref[y][x];
    return r;
  endfunction

  task automatic issue_read(input int id, input int row, input logic [16:0] exp,
                            input logic [16:0] mask, input string name);
    rd_exp_t e;
    @(posedge clk); #1;
    rd_row   = 5'(row);
    rd_issue = 1'b1;
    e.id = id; e.row = row; e.exp = exp; e.mask = mask; e.name = name;
    rq.push_back(e);
  endtask

  task automatic end_reads();
    @(posedge clk); #1;
    rd_issue = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_grid(input int id, input int w, input int h, input string name);
    logic [16:0] m;
    m = 17'((32'd1 << w) - 32'd1);
    for (int r = 0; r < h; r++) issue_read(id, r, mrow(r, w), m, $sformatf("%s row %0d", name, r));
    end_reads();
  endtask

  task automatic do_start(input int id, input logic [15:0] sd, input logic md, input bit exp_done,
                          input int lat, input logic ovf, input string name, output int t_acc);
    dn_exp_t e;
    @(posedge clk); #1;
    seed_v[id]  = sd;
    mode_v[id]  = md;
    start_v[id] = 1'b1;
    @(posedge clk); #1;
    t_acc       = cyc;
    start_v[id] = 1'b0;
    if (exp_done) begin
      e.id = id; e.t_acc = t_acc; e.lat = lat; e.ovf = ovf; e.name = name;
      dq.push_back(e);
    end
  endtask

  task automatic wait_done(input int id, input int budget, input string name);
    int n = 0;
    while (!done_v[id] && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done_v[id]) check({name, " done timeout"}, 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  // open-square count and entry-to-exit reachability on the captured 17x17 grid
  task automatic check_props(input string name);
    int open_cnt = 0;
    bit vis [17][17];
    int qx[$], qy[$];
    int cx, cy, nx, ny;
    int dx[4] = '{0, 1, 0, -1};
    int dy[4] = '{-1, 0, 1, 0};
    for (int y = 0; y < 17; y++) for (int x = 0; x < 17; x++) begin
      vis[y][x] = 1'b0;
      if (!cap[y][x]) open_cnt++;
    end
    check({name, " open squares"}, 32'(open_cnt), 32'd129);
    vis[1][0] = 1'b1;
    qx.push_back(0);
    qy.push_back(1);
    while (qx.size() > 0) begin
      cx = qx.pop_front();
      cy = qy.pop_front();
      for (int d = 0; d < 4; d++) begin
        nx = cx + dx[d];
        ny = cy + dy[d];
        if (nx >= 0 && nx < 17 && ny >= 0 && ny < 17) begin
          if (!cap[ny][nx] && !vis[ny][nx]) begin
            vis[ny][nx] = 1'b1;
            qx.push_back(nx);
            qy.push_back(ny);
          end
        end
      end
    end
    check({name, " exit reachable"}, 32'(vis[15][16]), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish within 100k cycles");
    $fatal(1, "timeout");
  end

  initial begin
    int  t, lat;
    bit  ovf;
    reset    = 1'b0;
    start_v  = '0;
    mode_v   = '0;
    rd_row   = '0;
    for (int i = 0; i < 3; i++) seed_v[i] = '0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #1;

    // reset state
    check("reset busy", 32'(busy_v), 32'd0);
    check("reset done", 32'(done_v), 32'd0);
    check("reset overflow", 32'(ovf_v), 32'd0);
    check("reset lfsr", 32'(dut_a.lfsr), 32'hACE1);
    for (int r = 0; r < 17; r++) issue_read(0, r, 17'h1FFFF, 17'h1FFFF, $sformatf("reset row %0d", r));
    issue_read(0, 20, 17'h1FFFF, 17'h1FFFF, "out of range row");
    end_reads();

    // DFS 17x17 with ignored starts mid-run and on the completion edge
    model_gen(17, 17, 64, 16'h1234, 1'b0, lat, ovf);
    do_start(0, 16'h1234, 1'b0, 1'b1, 128, 1'b0, "dfs 1234", t);
    check("busy after accept", 32'(busy_v[0]), 32'd1);
    while (cyc < t + 40) begin @(posedge clk); #1; end
    seed_v[0] = 16'hFFFF; mode_v[0] = 1'b1; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    check("busy after mid start", 32'(busy_v[0]), 32'd1);
    while (cyc < t + 127) begin @(posedge clk); #1; end
    check("busy before completion", 32'(busy_v[0]), 32'd1);
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    check("done at completion", 32'(done_v[0]), 32'd1);
    @(posedge clk); #1;
    check("done held after start on completion", 32'(done_v[0]), 32'd1);
    check("busy low after start on completion", 32'(busy_v[0]), 32'd0);
    check_grid(0, 17, 17, "dfs 1234");
    check_props("dfs 1234");
    for (int y = 1; y < 16; y += 2) issue_read(0, y, 17'h0, 17'h0AAAA, $sformatf("dfs cells row %0d", y));
    end_reads();

    // start in DONE regenerates from a cleared grid
    model_gen(17, 17, 64, 16'h00FF, 1'b0, lat, ovf);
    do_start(0, 16'h00FF, 1'b0, 1'b1, 128, 1'b0, "dfs 00ff", t);
    check("done cleared on restart", 32'(done_v[0]), 32'd0);
    wait_done(0, 200, "dfs 00ff");
    check_grid(0, 17, 17, "dfs 00ff");
    check_props("dfs 00ff");

    // binary tree 9x7, seed 0 stands in for 16'hACE1
    model_gen(9, 7, 12, 16'h0000, 1'b1, lat, ovf);
    do_start(1, 16'h0000, 1'b1, 1'b1, 13, 1'b0, "bt seed0", t);
    wait_done(1, 50, "bt seed0");
    check_grid(1, 9, 7, "bt seed0");
    issue_read(1, 1, 17'h00100, 17'h001FF, "bt row 1 open");
    for (int y = 1; y <= 5; y++) issue_read(1, y, 17'h0, 17'h00002, $sformatf("bt col 1 row %0d", y));
    end_reads();

    // 4-entry stack overflows
    model_gen(17, 17, 4, 16'h1234, 1'b0, lat, ovf);
    do_start(2, 16'h1234, 1'b0, 1'b1, lat, 1'b1, "dfs ovf", t);
    wait_done(2, 200, "dfs ovf");
    check("overflow sticky", 32'(ovf_v[2]), 32'd1);
    check_grid(2, 17, 17, "dfs ovf");
    issue_read(2, 1, 17'h0, 17'h00001, "ovf entry");
    issue_read(2, 15, 17'h0, 17'h10000, "ovf exit");
    end_reads();
    model_gen(17, 17, 4, 16'h5555, 1'b0, lat, ovf);
    do_start(2, 16'h5555, 1'b0, 1'b1, lat, ovf, "dfs ovf 5555", t);
    check("overflow cleared on start", 32'(ovf_v[2]), 32'd0);
    wait_done(2, 200, "dfs ovf 5555");

    // async reset mid-DFS, then a full rerun
    do_start(0, 16'h1234, 1'b0, 1'b0, 0, 1'b0, "dfs aborted", t);
    while (cyc < t + 50) begin @(posedge clk); #1; end
    #3 reset = 1'b0;
    #1;
    check("async reset busy", 32'(busy_v[0]), 32'd0);
    check("async reset done", 32'(done_v[0]), 32'd0);
    check("async reset overflow", 32'(ovf_v[0]), 32'd0);
    check("async reset rd_data", 32'(rd_data_a), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int r = 0; r < 17; r++) issue_read(0, r, 17'h1FFFF, 17'h1FFFF, $sformatf("post-reset row %0d", r));
    end_reads();
    model_gen(17, 17, 64, 16'h1234, 1'b0, lat, ovf);
    do_start(0, 16'h1234, 1'b0, 1'b1, 128, 1'b0, "dfs rerun", t);
    wait_done(0, 200, "dfs rerun");
    check_grid(0, 17, 17, "dfs rerun");

    check("busy and done exclusive", 32'(bd_viol), 32'd0);
    check("scoreboard drained", 32'(rq.size() + dq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
